// File: rtl/riscv_ext_pkg.sv
// Shared definitions for the extraction-FIFO stream path: FSM state encoding,
// the FIFO's bus address and the drop-counter width.
package riscv_ext_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } ext_state_t;

    localparam logic [31:0] EXT_FIFO_ADDRESS = 32'h0001_0150;
    localparam int          DROP_COUNT_W     = 16;

endpackage

// File: rtl/ext_fifo_stream_if.sv
// Bundle of the push port, the outgoing valid/ready stream and the status
// outputs of ext_fifo_stream; master is the FIFO side, slave the host side.
interface ext_fifo_stream_if
    import riscv_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 6
);
    logic                    WR_ENB;
    logic [DATA_WIDTH-1:0]   WR_DATA;
    logic                    FLUSH;
    logic [DATA_WIDTH-1:0]   M_TDATA;
    logic                    M_TVALID;
    logic                    M_TREADY;
    logic                    M_TLAST;
    logic [DEPTH_LOG2:0]     FILL_LEVEL;
    logic                    OVERFLOW;
    logic [DROP_COUNT_W-1:0] DROP_COUNT;

    modport master (
        input  WR_ENB, WR_DATA, FLUSH, M_TREADY,
        output M_TDATA, M_TVALID, M_TLAST, FILL_LEVEL, OVERFLOW, DROP_COUNT
    );

    modport slave (
        output WR_ENB, WR_DATA, FLUSH, M_TREADY,
        input  M_TDATA, M_TVALID, M_TLAST, FILL_LEVEL, OVERFLOW, DROP_COUNT
    );
endinterface

// File: rtl/ext_fifo_ram.sv
// Simple dual-port storage for the extraction FIFO: one write port, one
// read port with registered (synchronous) read data and a read enable.
module ext_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ext_fifo_stream.sv
// Extraction-FIFO buffer draining to the host in fixed bursts with TLAST.
// Define EXT_FIFO_TIMEOUT_EN to auto-flush partial bursts after TIMEOUT_CYCLES idle cycles.
module ext_fifo_stream
    import riscv_ext_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 6,
    parameter int BURST_LEN      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    ext_fifo_stream_if.master bus
);

    localparam int            PW          = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] BURST_BEATS = PW'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << DEPTH_LOG2)) begin : g_bad_burst_len
        $error("ext_fifo_stream: BURST_LEN must lie in 1..2**DEPTH_LOG2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ext_fifo_stream: TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic [DROP_COUNT_W-1:0] sat_inc(input logic [DROP_COUNT_W-1:0] v);
        return (&v) ? v : v + DROP_COUNT_W'(1);
    endfunction

    ext_state_t state, state_nxt;
    logic       flush_pend, flush_pend_nxt;
    logic       flush_req;
    logic       timeout_hit;

    // rd_ptr frees space on pop; fetch_ptr runs one word ahead whenever a beat is on the output
    logic [PW-1:0] wr_ptr, rd_ptr, fetch_ptr;
    logic [PW-1:0] fill;
    logic          full, push, pop;

    logic [PW-1:0]         beats, beats_cur;
    logic                  load;
    logic                  tvalid, tlast;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  overflow;
    logic [DROP_COUNT_W-1:0] drop_count;

    assign fill      = wr_ptr - rd_ptr;
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign pop       = tvalid && bus.M_TREADY;
    assign push      = bus.WR_ENB && (!full || pop);
    assign flush_req = flush_pend || timeout_hit;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        flush_pend_nxt = flush_pend;
        case (state)
            IDLE: begin
                if (fill >= BURST_BEATS) begin
                    state_nxt = BURST;
                end else if (flush_req && fill != '0) begin
                    state_nxt = DRAIN;
                end else if (flush_req) begin
                    flush_pend_nxt = 1'b0;
                end
            end
            BURST: begin
                if (pop && tlast) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (pop && tlast) begin
                    state_nxt      = IDLE;
                    flush_pend_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A new request always survives a same-cycle clear
        if (bus.FLUSH || timeout_hit) begin
            flush_pend_nxt = 1'b1;
        end
    end

    // Output logic: the first beat is fetched on the IDLE exit edge itself
    always_comb begin
        beats_cur = beats;
        load      = 1'b0;
        case (state)
            IDLE: begin
                beats_cur = (state_nxt == BURST) ? BURST_BEATS : fill;
                load      = (state_nxt != IDLE);
            end
            default: begin
                load = (beats != '0) && (!tvalid || pop);
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            beats      <= '0;
            tvalid     <= 1'b0;
            tlast      <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (load) begin
                fetch_ptr <= fetch_ptr + PW'(1);
                beats     <= beats_cur - PW'(1);
                tvalid    <= 1'b1;
                tlast     <= (beats_cur == PW'(1));
            end else if (pop) begin
                tvalid <= 1'b0;
                tlast  <= 1'b0;
            end
            if (bus.WR_ENB && !push) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

`ifdef EXT_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          idle_run;

    assign idle_run    = (state == IDLE) && (fill != '0) && (fill < BURST_BEATS);
    assign timeout_hit = idle_run && !push && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (!idle_run || push || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    ext_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr[PW-2:0]),
        .wr_data (bus.WR_DATA),
        .rd_en   (load),
        .rd_addr (fetch_ptr[PW-2:0]),
        .rd_data (ram_q)
    );

    // RAM read register has no reset, so data is masked to zero while no beat is held
    assign bus.M_TDATA    = tvalid ? ram_q : '0;
    assign bus.M_TVALID   = tvalid;
    assign bus.M_TLAST    = tlast;
    assign bus.FILL_LEVEL = fill;
    assign bus.OVERFLOW   = overflow;
    assign bus.DROP_COUNT = drop_count;

endmodule
